fetch_unit: RTL and testbench

- Decoupled instruction-fetch front end. Replaces the single-register fetch stage with a request/response instruction-memory interface, a reservation buffer of in-flight and fetched instructions, and a valid/ready handoff to decode.
- Redirects from execute (branch/jump/jalr) flush the buffer. Stale memory responses are discarded by a drop counter.
- Sits between instruction memory and decode_stage.

---
 rtl/fetch_unit_pkg.sv | 32 +++
 rtl/fetch_rsv_buffer.sv | 89 ++++++++
 rtl/fetch_unit.sv | 95 +++++++++
 tb/tb_fetch_unit.sv | 389 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared types and constants for the fetch front end
// Purpose: defaults for fetch width/depth, PC alignment helper, and the
// record types used on the instruction-memory side and inside the buffer.
// Ports: none (package).
package fetch_unit_pkg;

    localparam int FETCH_XLEN  = 32;
    localparam int FETCH_DEPTH = 4;

    localparam logic [31:0] INSTR_ALIGN_MASK = 32'hFFFF_FFFC;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        filled;
    } fetch_entry_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
    } imem_req_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] data;
    } imem_rsp_t;

    function automatic logic [31:0] align_pc(input logic [31:0] addr);
        return addr & INSTR_ALIGN_MASK;
    endfunction

endpackage

// File: rtl/fetch_rsv_buffer.sv
// rtl/fetch_rsv_buffer.sv - circular reservation buffer of in-flight/fetched instructions
// Purpose: holds {pc, instr, filled} per entry with head (pop), fill (oldest
// unfilled) and tail (alloc) pointers. Flush empties the buffer and wins over
// alloc/fill/pop in the same cycle.
// Ports: clk, reset (sync, active-high); flush_i, alloc_i/alloc_pc_i,
// fill_i/fill_data_i, pop_i controls; head_filled_o/head_pc_o/head_instr_o
// describe the head entry; occupancy_o and unfilled_o are entry counts.
module fetch_rsv_buffer #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush_i,
    input  logic                       alloc_i,
    input  logic [XLEN-1:0]            alloc_pc_i,
    input  logic                       fill_i,
    input  logic [XLEN-1:0]            fill_data_i,
    input  logic                       pop_i,
    output logic                       head_filled_o,
    output logic [XLEN-1:0]            head_pc_o,
    output logic [XLEN-1:0]            head_instr_o,
    output logic [$clog2(DEPTH):0]     occupancy_o,
    output logic [$clog2(DEPTH):0]     unfilled_o
);
    localparam int AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0]       head_q, head_d, tail_q, tail_d, fill_q, fill_d;
    logic [DEPTH-1:0]  filled_q, filled_d;
    logic [XLEN-1:0]   pc_mem    [DEPTH];
    logic [XLEN-1:0]   instr_mem [DEPTH];

    always_comb begin
        head_d   = head_q;
        tail_d   = tail_q;
        fill_d   = fill_q;
        filled_d = filled_q;
        if (flush_i) begin
            head_d   = tail_q;
            fill_d   = tail_q;
            filled_d = '0;
        end else begin
            if (pop_i) begin
                filled_d[head_q[AW-1:0]] = 1'b0;
                head_d = head_q + 1'b1;
            end
            if (fill_i) begin
                filled_d[fill_q[AW-1:0]] = 1'b1;
                fill_d = fill_q + 1'b1;
            end
            if (alloc_i) begin
                filled_d[tail_q[AW-1:0]] = 1'b0;
                tail_d = tail_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q   <= '0;
            tail_q   <= '0;
            fill_q   <= '0;
            filled_q <= '0;
        end else begin
            head_q   <= head_d;
            tail_q   <= tail_d;
            fill_q   <= fill_d;
            filled_q <= filled_d;
        end
    end

    // Payload storage needs no reset: the filled bits qualify it.
    always_ff @(posedge clk) begin
        if (alloc_i && !flush_i) begin
            pc_mem[tail_q[AW-1:0]] <= alloc_pc_i;
        end
        if (fill_i && !flush_i) begin
            instr_mem[fill_q[AW-1:0]] <= fill_data_i;
        end
    end

    assign head_filled_o = filled_q[head_q[AW-1:0]];
    assign head_pc_o     = pc_mem[head_q[AW-1:0]];
    assign head_instr_o  = instr_mem[head_q[AW-1:0]];
    assign occupancy_o   = tail_q - head_q;
    assign unfilled_o    = tail_q - fill_q;

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - decoupled instruction fetch with imem req/rsp and decode handoff
// Purpose: owns the fetch pc, the request-issue rule and the stale-response
// drop counter; buffering lives in fetch_rsv_buffer.
// Ports: clk, reset (sync, active-high); redirect_valid/redirect_target from
// execute; imem_req_valid/ready/addr request channel; imem_rsp_valid/data
// in-order response channel (no backpressure); id_valid/ready/instruction/pc
// handoff to decode.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int              XLEN     = FETCH_XLEN,
    parameter int              DEPTH    = FETCH_DEPTH,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [XLEN-1:0] id_instruction,
    output logic [XLEN-1:0] id_pc
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [XLEN-1:0] pc_q, pc_d;
    logic [CW-1:0]   drop_q, drop_d;
    logic [CW-1:0]   occupancy, unfilled;
    logic [CW:0]     in_flight;
    logic            head_filled;
    logic            req_fire, rsp_drop, rsp_fill, id_fire;

    // Buffered entries plus responses still owed to a flushed epoch bound the
    // total outstanding imem traffic.
    assign in_flight      = {1'b0, occupancy} + {1'b0, drop_q};
    assign imem_req_valid = !reset && (in_flight < (CW+1)'(DEPTH));
    assign imem_req_addr  = pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign rsp_drop = imem_rsp_valid && (drop_q != '0);
    assign rsp_fill = imem_rsp_valid && (drop_q == '0) && (unfilled != '0);

    assign id_valid = !reset && head_filled;
    assign id_fire  = id_valid && id_ready;

    always_comb begin
        pc_d   = pc_q;
        drop_d = drop_q - {{(CW-1){1'b0}}, rsp_drop};
        if (redirect_valid) begin
            pc_d = {redirect_target[XLEN-1:2], 2'b00};
            // Everything still unanswered after this cycle becomes stale,
            // including a request that fires now with the old pc.
            drop_d = drop_q - {{(CW-1){1'b0}}, rsp_drop}
                   + unfilled - {{(CW-1){1'b0}}, rsp_fill}
                   + {{(CW-1){1'b0}}, req_fire};
        end else if (req_fire) begin
            pc_d = pc_q + XLEN'(4);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q   <= RESET_PC;
            drop_q <= '0;
        end else begin
            pc_q   <= pc_d;
            drop_q <= drop_d;
        end
    end

    fetch_rsv_buffer #(
        .XLEN  (XLEN),
        .DEPTH (DEPTH)
    ) u_rsv_buffer (
        .clk           (clk),
        .reset         (reset),
        .flush_i       (redirect_valid),
        .alloc_i       (req_fire),
        .alloc_pc_i    (pc_q),
        .fill_i        (rsp_fill),
        .fill_data_i   (imem_rsp_data),
        .pop_i         (id_fire),
        .head_filled_o (head_filled),
        .head_pc_o     (id_pc),
        .head_instr_o  (id_instruction),
        .occupancy_o   (occupancy),
        .unfilled_o    (unfilled)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit
module tb_fetch_unit;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instruction;
    logic [31:0] id_pc;

    always #5 clk = ~clk;

    fetch_unit #(
        .XLEN     (32),
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_rsp_valid  (imem_rsp_valid),
        .imem_rsp_data   (imem_rsp_data),
        .id_valid        (id_valid),
        .id_ready        (id_ready),
        .id_instruction  (id_instruction),
        .id_pc           (id_pc)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    pend_t       imem_q[$];
    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          lat = 1;
    logic [31:0] pc_model = RESET_PC;
    logic [31:0] prev_req_addr = 32'h0;
    logic        s_req_valid, s_id_valid, s_rsp_valid;
    logic [31:0] s_addr;
    logic        last_req_fire, last_id_fire;
    bit          saw_wrap = 0;
    bit          watch_first = 0;
    bit          first_seen = 0;
    logic [31:0] first_pc;

    function automatic logic [31:0] imem_word(input logic [31:0] a);
        return a ^ 32'hA5A5_0F0F;
    endfunction

    // One clock cycle: drive inputs, sample at negedge, update models, advance.
    task automatic tick(input logic rq_rdy, input logic i_rdy,
                        input logic redir, input logic [31:0] tgt);
        exp_t  e;
        pend_t p;
        imem_req_ready  = rq_rdy;
        id_ready        = i_rdy;
        redirect_valid  = redir;
        redirect_target = tgt;
        if (!reset && imem_q.size() > 0 && imem_q[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = imem_word(imem_q[0].addr);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'h0;
        end
        @(negedge clk);
        s_req_valid   = imem_req_valid;
        s_addr        = imem_req_addr;
        s_id_valid    = id_valid;
        s_rsp_valid   = imem_rsp_valid;
        last_req_fire = imem_req_valid && rq_rdy;
        last_id_fire  = id_valid && i_rdy;
        if (!reset) begin
            if (imem_req_valid) begin
                checks++;
                if (imem_req_addr !== pc_model) begin
                    errors++;
                    $display("FAIL req_addr: got %h, expected %h (cycle %0d)", imem_req_addr, pc_model, cyc);
                end
            end
            if (last_id_fire) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL id_spurious: got pc %h instr %h, expected no instruction", id_pc, id_instruction);
                end else begin
                    e = exp_q.pop_front();
                    if (id_pc !== e.pc || id_instruction !== e.instr) begin
                        errors++;
                        $display("FAIL id_data: got pc %h instr %h, expected pc %h instr %h", id_pc, id_instruction, e.pc, e.instr);
                    end
                end
                if (watch_first) begin
                    watch_first = 0;
                    first_seen  = 1;
                    first_pc    = id_pc;
                end
            end
            if (last_req_fire) begin
                p.addr = imem_req_addr;
                p.due  = cyc + lat;
                imem_q.push_back(p);
                checks++;
                if (imem_q.size() > DEPTH) begin
                    errors++;
                    $display("FAIL outstanding: got %0d, expected at most %0d", imem_q.size(), DEPTH);
                end
                if (!redir) begin
                    e.pc    = imem_req_addr;
                    e.instr = imem_word(imem_req_addr);
                    exp_q.push_back(e);
                end
                if (imem_req_addr == 32'h0 && prev_req_addr == 32'hFFFF_FFFC) saw_wrap = 1;
                prev_req_addr = imem_req_addr;
                pc_model = pc_model + 32'd4;
            end
            if (redir) begin
                exp_q.delete();
                pc_model = {tgt[31:2], 2'b00};
            end
        end
        @(posedge clk);
        if (imem_rsp_valid) void'(imem_q.pop_front());
        if (reset) begin
            imem_q.delete();
            exp_q.delete();
            pc_model      = RESET_PC;
            prev_req_addr = 32'h0;
        end
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(1'b0, 1'b0, 1'b0, 32'h0);
        tick(1'b0, 1'b0, 1'b0, 32'h0);
        reset = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((exp_q.size() > 0 || imem_q.size() > 0) && n < budget) begin
            tick(1'b0, 1'b1, 1'b0, 32'h0);
            n++;
        end
        checks++;
        if (exp_q.size() > 0 || imem_q.size() > 0) begin
            errors++;
            $display("FAIL drain_timeout: got %0d expected/%0d pending left, expected 0/0", exp_q.size(), imem_q.size());
        end
        tick(1'b0, 1'b1, 1'b0, 32'h0);
        checks++;
        if (s_id_valid !== 1'b0) begin
            errors++;
            $display("FAIL empty_id_valid: got %b, expected 0", s_id_valid);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(1'b1, 1'b1, 1'b0, 32'h0);
        checks++;
        if (s_req_valid !== 1'b0 || s_id_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got req_valid %b id_valid %b, expected 0 0", s_req_valid, s_id_valid);
        end
        tick(1'b0, 1'b0, 1'b0, 32'h0);
        reset = 1'b0;
        tick(1'b0, 1'b0, 1'b0, 32'h0);
        checks++;
        if (s_req_valid !== 1'b1 || s_addr !== RESET_PC || s_id_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: got req_valid %b addr %h id_valid %b, expected 1 %h 0", s_req_valid, s_addr, s_id_valid, RESET_PC);
        end
    endtask

    task automatic test_stream();
        int first = -1;
        do_reset();
        lat = 1;
        for (int i = 0; i < 20; i++) begin
            tick(1'b1, 1'b1, 1'b0, 32'h0);
            if (s_id_valid && first < 0) first = i;
            if (i >= 2) begin
                checks++;
                if (s_id_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL stream_throughput: got id_valid %b at cycle %0d, expected 1", s_id_valid, i);
                end
            end
        end
        checks++;
        if (first != 2) begin
            errors++;
            $display("FAIL stream_latency: got first id at cycle %0d, expected 2", first);
        end
        drain(40);
    endtask

    task automatic test_backpressure();
        int fires = 0;
        do_reset();
        lat = 1;
        for (int i = 0; i < 10; i++) begin
            tick(1'b1, 1'b0, 1'b0, 32'h0);
            if (last_req_fire) fires++;
        end
        checks++;
        if (fires != DEPTH || s_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL full_stall: got %0d fires req_valid %b, expected %0d fires req_valid 0", fires, s_req_valid, DEPTH);
        end
        tick(1'b1, 1'b1, 1'b0, 32'h0);
        checks++;
        if (last_id_fire !== 1'b1 || s_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL pop_cycle: got id_fire %b req_valid %b, expected 1 0", last_id_fire, s_req_valid);
        end
        tick(1'b1, 1'b0, 1'b0, 32'h0);
        checks++;
        if (last_req_fire !== 1'b1) begin
            errors++;
            $display("FAIL resume_after_pop: got req_fire %b, expected 1", last_req_fire);
        end
        tick(1'b1, 1'b0, 1'b0, 32'h0);
        checks++;
        if (s_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL refull: got req_valid %b, expected 0", s_req_valid);
        end
        drain(40);
    endtask

    task automatic test_redirect();
        int n = 0;
        do_reset();
        lat = 4;
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, 1'b0, 32'h0);
        tick(1'b0, 1'b1, 1'b1, 32'h0000_0103);
        watch_first = 1;
        first_seen  = 0;
        tick(1'b1, 1'b1, 1'b0, 32'h0);
        checks++;
        if (s_req_valid !== 1'b1 || s_addr !== 32'h100) begin
            errors++;
            $display("FAIL redirect_addr: got req_valid %b addr %h, expected 1 00000100", s_req_valid, s_addr);
        end
        while (!first_seen && n < 30) begin
            tick(1'b1, 1'b1, 1'b0, 32'h0);
            n++;
        end
        checks++;
        if (!first_seen || first_pc !== 32'h100) begin
            errors++;
            $display("FAIL redirect_first_pc: got seen %0d pc %h, expected 1 00000100", first_seen, first_pc);
        end
        watch_first = 0;
        drain(60);
    endtask

    task automatic test_collide();
        int n = 0;
        do_reset();
        lat = 1;
        for (int i = 0; i < 6; i++) tick(1'b1, 1'b1, 1'b0, 32'h0);
        tick(1'b1, 1'b1, 1'b1, 32'h0000_0200);
        checks++;
        if (last_req_fire !== 1'b1 || s_rsp_valid !== 1'b1) begin
            errors++;
            $display("FAIL collide_setup: got req_fire %b rsp_valid %b, expected 1 1", last_req_fire, s_rsp_valid);
        end
        watch_first = 1;
        first_seen  = 0;
        while (!first_seen && n < 30) begin
            tick(1'b1, 1'b1, 1'b0, 32'h0);
            n++;
        end
        checks++;
        if (!first_seen || first_pc !== 32'h200) begin
            errors++;
            $display("FAIL collide_first_pc: got seen %0d pc %h, expected 1 00000200", first_seen, first_pc);
        end
        watch_first = 0;
        drain(40);
    endtask

    task automatic test_random();
        logic rr, ir, rd;
        logic [31:0] tg;
        do_reset();
        lat = 3;
        for (int i = 0; i < 300; i++) begin
            rr = 1'($urandom_range(0, 1));
            ir = ($urandom_range(0, 3) != 0);
            rd = ($urandom_range(0, 15) == 0);
            tg = $urandom & 32'h0000_FFFF;
            tick(rr, ir, rd, tg);
        end
        drain(200);
    endtask

    task automatic test_wrap();
        do_reset();
        lat = 1;
        saw_wrap = 0;
        tick(1'b1, 1'b1, 1'b1, 32'hFFFF_FFF8);
        for (int i = 0; i < 10; i++) tick(1'b1, 1'b1, 1'b0, 32'h0);
        checks++;
        if (!saw_wrap) begin
            errors++;
            $display("FAIL pc_wrap: got no request 00000000 after FFFFFFFC, expected one");
        end
        drain(40);
    endtask

    task automatic test_reset_mid();
        do_reset();
        lat = 2;
        for (int i = 0; i < 8; i++) tick(1'b1, 1'b1, 1'b0, 32'h0);
        reset = 1'b1;
        tick(1'b1, 1'b1, 1'b0, 32'h0);
        checks++;
        if (s_req_valid !== 1'b0 || s_id_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_outputs: got req_valid %b id_valid %b, expected 0 0", s_req_valid, s_id_valid);
        end
        reset = 1'b0;
        tick(1'b1, 1'b1, 1'b0, 32'h0);
        checks++;
        if (s_req_valid !== 1'b1 || s_addr !== RESET_PC || s_id_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_restart: got req_valid %b addr %h id_valid %b, expected 1 %h 0", s_req_valid, s_addr, s_id_valid, RESET_PC);
        end
        for (int i = 0; i < 10; i++) tick(1'b1, 1'b1, 1'b0, 32'h0);
        drain(40);
    endtask

    initial begin
        reset           = 1'b1;
        redirect_valid  = 1'b0;
        redirect_target = 32'h0;
        imem_req_ready  = 1'b0;
        imem_rsp_valid  = 1'b0;
        imem_rsp_data   = 32'h0;
        id_ready        = 1'b0;
        #1;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_collide();
        test_random();
        test_wrap();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no finish, expected finish within bound");
        $fatal(1, "timeout");
    end

endmodule
